// File: rtl/password_check_if.sv
// Keypad-to-password-checker bus: digit/strobe/control from the keypad side,
// status back to the actuator and indicator side.
interface password_check_if #(
  parameter int DIGIT_W    = 3,
  parameter int NUM_DIGITS = 4,
  parameter int MAX_TRIES  = 3
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [DIGIT_W-1:0] data;
  logic               dk;
  logic               cancel;
  logic               prog;
  logic               unlocked;
  logic               fail;
  logic               alarm;
  logic [TW-1:0]      tries_left;
  logic [CW-1:0]      digit_cnt;

  modport master (
    output data, dk, cancel, prog,
    input  unlocked, fail, alarm, tries_left, digit_cnt
  );

  modport slave (
    input  data, dk, cancel, prog,
    output unlocked, fail, alarm, tries_left, digit_cnt
  );
endinterface

// File: rtl/password_check.sv
// Keypad password checker: collects NUM_DIGITS digits, compares them with the
// stored password, opens for UNLOCK_CYCLES on a match and raises the alarm for
// LOCKOUT_CYCLES after MAX_TRIES consecutive wrong codes.
// Optional feature macro: PWD_CHANGE_EN (adds the PROGRAM state, entered with
// prog while open, which rewrites the stored password).
module password_check #(
  parameter int DIGIT_W        = 3,
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 100,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_PWD = 12'o1234
) (
  input  logic             clk,
  input  logic             reset,
  password_check_if.slave  bus
);
  localparam int PW      = DIGIT_W * NUM_DIGITS;
  localparam int TW      = $clog2(MAX_TRIES + 1);
  localparam int CW      = $clog2(NUM_DIGITS + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, LOCKOUT
`ifdef PWD_CHANGE_EN
    , PROGRAM
`endif
  } state_t;

  state_t           state, state_nxt;
  logic             dk_p0, vld_p1;
  logic [PW-1:0]    entry_buf, entry_nxt, shifted;
  logic [PW-1:0]    pwd;
  logic [CW-1:0]    cnt_q, cnt_nxt, cnt_inc;
  logic [TW-1:0]    tries_q, tries_nxt;
  logic [TMR_W-1:0] tmr_q, tmr_nxt;
  logic             unlocked_q, fail_q, alarm_q;
  logic             fail_nxt;
  logic             accepting, rise, cap, last, match;

  // A digit is only accepted while the machine is collecting one; strobes in
  // CHECK/OPEN/LOCKOUT are dropped at detection so nothing is queued.
  always_comb begin
    accepting = (state == IDLE) || (state == ENTRY);
`ifdef PWD_CHANGE_EN
    accepting = accepting || (state == PROGRAM);
`endif
    rise    = bus.dk & ~dk_p0;
    cap     = vld_p1 & accepting & ~bus.cancel;
    cnt_inc = cnt_q + CW'(1);
    last    = cap && (cnt_inc == CW'(NUM_DIGITS));
    shifted = (entry_buf << DIGIT_W) | PW'(bus.data);
    match   = (entry_buf == pwd);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ENTRY: begin
        if (bus.cancel) state_nxt = IDLE;
        else if (cap)   state_nxt = last ? CHECK : ENTRY;
      end
      CHECK: begin
        if (match)                    state_nxt = OPEN;
        else if (tries_q == TW'(1))   state_nxt = LOCKOUT;
        else                          state_nxt = IDLE;
      end
      OPEN: begin
        if (bus.cancel)               state_nxt = IDLE;
`ifdef PWD_CHANGE_EN
        else if (bus.prog)            state_nxt = PROGRAM;
`endif
        else if (tmr_q == TMR_W'(1))  state_nxt = IDLE;
      end
      LOCKOUT: begin
        if (tmr_q == TMR_W'(1))       state_nxt = IDLE;
      end
`ifdef PWD_CHANGE_EN
      PROGRAM: begin
        if (bus.cancel || last)       state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the entry buffer, counters, timer and the fail pulse.
  always_comb begin
    entry_nxt = entry_buf;
    cnt_nxt   = cnt_q;
    tries_nxt = tries_q;
    tmr_nxt   = tmr_q;
    fail_nxt  = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (bus.cancel) begin
          entry_nxt = '0;
          cnt_nxt   = '0;
        end else if (cap) begin
          entry_nxt = shifted;
          cnt_nxt   = cnt_inc;
        end
      end
      CHECK: begin
        entry_nxt = '0;
        cnt_nxt   = '0;
        if (match) begin
          tries_nxt = TW'(MAX_TRIES);
          tmr_nxt   = TMR_W'(UNLOCK_CYCLES);
        end else begin
          fail_nxt  = 1'b1;
          tries_nxt = tries_q - TW'(1);
          tmr_nxt   = TMR_W'(LOCKOUT_CYCLES);
        end
      end
      OPEN: tmr_nxt = tmr_q - TMR_W'(1);
      LOCKOUT: begin
        tmr_nxt = tmr_q - TMR_W'(1);
        if (tmr_q == TMR_W'(1)) tries_nxt = TW'(MAX_TRIES);
      end
`ifdef PWD_CHANGE_EN
      PROGRAM: begin
        if (bus.cancel || last) begin
          entry_nxt = '0;
          cnt_nxt   = '0;
        end else if (cap) begin
          entry_nxt = shifted;
          cnt_nxt   = cnt_inc;
        end
      end
`endif
      default: ;
    endcase
  end

  // Stage p0: strobe history; stage p1: pending capture; then datapath/outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dk_p0      <= 1'b0;
      vld_p1     <= 1'b0;
      entry_buf  <= '0;
      cnt_q      <= '0;
      tries_q    <= TW'(MAX_TRIES);
      tmr_q      <= '0;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      dk_p0      <= bus.dk;
      vld_p1     <= rise & accepting;
      entry_buf  <= entry_nxt;
      cnt_q      <= cnt_nxt;
      tries_q    <= tries_nxt;
      tmr_q      <= tmr_nxt;
      unlocked_q <= (state_nxt == OPEN);
      fail_q     <= fail_nxt;
      alarm_q    <= (state_nxt == LOCKOUT);
    end
  end

`ifdef PWD_CHANGE_EN
  // Stored password: rewritten by the last digit of a PROGRAM entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      pwd <= DEFAULT_PWD;
    else if ((state == PROGRAM) && !bus.cancel && last) pwd <= shifted;
  end
`else
  assign pwd = DEFAULT_PWD;
`endif

  assign bus.unlocked   = unlocked_q;
  assign bus.fail       = fail_q;
  assign bus.alarm      = alarm_q;
  assign bus.tries_left = tries_q;
  assign bus.digit_cnt  = cnt_q;
endmodule

// File: tb/tb_password_check.sv
// Bench for password_check: table of codes with a scoreboard of expected
// outcomes (unlock / fail), plus hand sequences for latency, pulse widths,
// lockout, cancel, held strobe and asynchronous reset.
module tb_password_check;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  password_check_if #(.DIGIT_W(3), .NUM_DIGITS(4), .MAX_TRIES(3)) bus ();
  password_check dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int sb_q[$];
  bit prev_unl = 1'b0;

  typedef struct {
    logic [11:0] code;
    int          unl;
    int          tries;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome monitor: every unlock rise or fail pulse consumes one expectation.
  always @(posedge clk) begin
    int got;
    #1;
    if (reset && (bus.fail || (bus.unlocked && !prev_unl))) begin
      got = bus.fail ? 0 : 1;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL outcome_unexpected: got %0d expected none at %0t", got, $time);
      end else begin
        check("outcome", got, sb_q.pop_front());
      end
    end
    prev_unl = bus.unlocked;
  end

  task automatic press(input logic [2:0] d, input int hold);
    @(negedge clk);
    bus.data = d;
    bus.dk   = 1'b1;
    repeat (hold) @(negedge clk);
    bus.dk = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_code(input logic [11:0] code);
    for (int i = 0; i < 4; i++) press(code[(3-i)*3 +: 3], 1);
  endtask

  task automatic wait_sb(input string name);
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    check(name, sb_q.size(), 0);
  endtask

  task automatic relock();
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("relock", bus.unlocked, 0);
  endtask

  // Drives the last digit by hand and returns right after the CHECK edge.
  task automatic last_digit(input logic [2:0] d);
    @(negedge clk);
    bus.data = d;
    bus.dk   = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.dk = 1'b0;
    @(posedge clk); #1;
    check("cnt_at_check", bus.digit_cnt, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{12'o1234, 1, 3};
    vecs[1] = '{12'o1235, 0, 2};
    vecs[2] = '{12'o1234, 1, 3};
    vecs[3] = '{12'o7777, 0, 2};
    vecs[4] = '{12'o0000, 0, 1};
    vecs[5] = '{12'o1234, 1, 3};
    vecs[6] = '{12'o4321, 0, 2};
    vecs[7] = '{12'o1234, 1, 3};

    reset = 1'b0;
    bus.data = '0; bus.dk = 1'b0; bus.cancel = 1'b0; bus.prog = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_unlocked", bus.unlocked, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_alarm", bus.alarm, 0);
    check("rst_tries", bus.tries_left, 3);
    check("rst_cnt", bus.digit_cnt, 0);
    reset = 1'b1;

    // Latency and unlock duration.
    sb_q.push_back(1);
    press(3'd1, 1); press(3'd2, 1); press(3'd3, 1);
    @(negedge clk);
    bus.data = 3'd4; bus.dk = 1'b1;
    @(posedge clk); #1;
    check("lat_edge_k", bus.unlocked, 0);
    @(negedge clk); bus.dk = 1'b0;
    @(posedge clk); #1;
    check("lat_edge_k1_unl", bus.unlocked, 0);
    check("lat_edge_k1_cnt", bus.digit_cnt, 4);
    @(posedge clk); #1;
    check("lat_edge_k2_unl", bus.unlocked, 1);
    check("lat_edge_k2_cnt", bus.digit_cnt, 0);
    check("lat_tries", bus.tries_left, 3);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.unlocked) n++;
      else break;
    end
    check("unlock_cycles", n, 50);
    wait_sb("lat_outcome");

    // Fail pulse width.
    sb_q.push_back(0);
    press(3'd1, 1); press(3'd2, 1); press(3'd3, 1);
    last_digit(3'd5);
    check("fail_hi", bus.fail, 1);
    check("fail_tries", bus.tries_left, 2);
    @(posedge clk); #1;
    check("fail_lo", bus.fail, 0);
    check("fail_unl", bus.unlocked, 0);
    check("fail_cnt", bus.digit_cnt, 0);

    // Lockout after the third wrong code; digits pressed meanwhile are ignored.
    sb_q.push_back(0);
    enter_code(12'o7777);
    wait_sb("lock_f2");
    check("lock_tries1", bus.tries_left, 1);
    sb_q.push_back(0);
    press(3'd1, 1); press(3'd2, 1); press(3'd3, 1);
    last_digit(3'd6);
    check("lock_fail3", bus.fail, 1);
    check("lock_alarm_on", bus.alarm, 1);
    check("lock_tries0", bus.tries_left, 0);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.dk   = (i % 3 == 0);
      bus.data = 3'(i);
      @(posedge clk); #1;
      if (bus.alarm) n++;
      else break;
    end
    @(negedge clk);
    bus.dk = 1'b0;
    check("alarm_cycles", n, 100);
    check("lock_exit_tries", bus.tries_left, 3);
    repeat (2) @(negedge clk);
    check("lock_exit_cnt", bus.digit_cnt, 0);
    sb_q.push_back(1);
    enter_code(12'o1234);
    wait_sb("lock_recover");
    relock();

    // Table of codes.
    foreach (vecs[i]) begin
      sb_q.push_back(vecs[i].unl);
      enter_code(vecs[i].code);
      wait_sb("vec_outcome");
      check("vec_tries", bus.tries_left, vecs[i].tries);
      check("vec_cnt", bus.digit_cnt, 0);
      check("vec_unl", bus.unlocked, vecs[i].unl);
      if (vecs[i].unl == 1) relock();
    end

    // Cancel colliding with a third capture, then a held strobe.
    press(3'd1, 1); press(3'd2, 1);
    @(negedge clk);
    bus.data = 3'd3; bus.dk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b1; bus.dk = 1'b0;
    @(posedge clk); #1;
    check("cancel_cnt", bus.digit_cnt, 0);
    check("cancel_tries", bus.tries_left, 3);
    @(negedge clk);
    bus.cancel = 1'b0;
    sb_q.push_back(1);
    press(3'd1, 10);
    check("held_cnt", bus.digit_cnt, 1);
    press(3'd2, 1); press(3'd3, 1); press(3'd4, 1);
    wait_sb("held_outcome");
    check("held_unl", bus.unlocked, 1);
`ifndef PWD_CHANGE_EN
    @(negedge clk); bus.prog = 1'b1;
    @(negedge clk); bus.prog = 1'b0;
    check("prog_ignored", bus.unlocked, 1);
`endif
    @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_open", bus.unlocked, 0);
    @(negedge clk);
    bus.cancel = 1'b0;

    // Asynchronous reset while open, during entry, and during lockout.
    sb_q.push_back(1);
    enter_code(12'o1234);
    wait_sb("ar_open");
    #2 reset = 1'b0;
    #1;
    check("ar_open_unl", bus.unlocked, 0);
    check("ar_open_tries", bus.tries_left, 3);
    @(negedge clk); reset = 1'b1;
    press(3'd1, 1); press(3'd2, 1);
    check("ar_entry_pre", bus.digit_cnt, 2);
    #3 reset = 1'b0;
    #1;
    check("ar_entry_cnt", bus.digit_cnt, 0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(0);
      enter_code(12'o0017);
      wait_sb("ar_lock_fail");
    end
    check("ar_lock_alarm_pre", bus.alarm, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_lock_alarm", bus.alarm, 0);
    check("ar_lock_tries", bus.tries_left, 3);
    @(negedge clk); reset = 1'b1;
    sb_q.push_back(1);
    enter_code(12'o1234);
    wait_sb("ar_recover");
    relock();

`ifdef PWD_CHANGE_EN
    // Password change, then reset restores the default.
    sb_q.push_back(1);
    enter_code(12'o1234);
    wait_sb("pg_open");
    @(negedge clk); bus.prog = 1'b1;
    @(negedge clk); bus.prog = 1'b0;
    check("pg_unl", bus.unlocked, 0);
    enter_code(12'o7070);
    check("pg_cnt", bus.digit_cnt, 0);
    sb_q.push_back(0);
    enter_code(12'o1234);
    wait_sb("pg_old_fails");
    sb_q.push_back(1);
    enter_code(12'o7070);
    wait_sb("pg_new_unlocks");
    relock();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    sb_q.push_back(1);
    enter_code(12'o1234);
    wait_sb("pg_default_back");
    relock();
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
